// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - buffered multi-lane argmax over one signed score vector
// Defining ARGMAX_MARGIN_EN adds second-max tracking with out_margin/out_lowc.
module argmax_classifier #(
    parameter int                   IC       = 10,
    parameter int                   DW       = 16,
    parameter int                   LANES    = 2,
    parameter int                   IDX_W    = $clog2(IC),
    parameter logic signed [DW-1:0] MARGIN_T = 16'sh0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IC-1:0][DW-1:0] in_scores,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_class,
    output logic [DW-1:0]         out_max
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DW:0]           out_margin,
    output logic                  out_lowc
`endif
);
    localparam int PTR_W = $clog2(IC + LANES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                state_q, state_d;
    logic [IC-1:0][DW-1:0] buf_q, buf_d;
    logic signed [DW-1:0]  max_q, max_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      class_q, class_d;
    logic [DW-1:0]         omax_q, omax_d;
    logic [PTR_W-1:0]      lane_k;
    logic signed [DW-1:0]  cand;
`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    logic signed [DW-1:0]  sec_q, sec_d;
    logic signed [DW:0]    margin_q, margin_d, diff;
    logic                  lowc_q, lowc_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            class_q     <= '0;
            omax_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
            sec_q       <= '0;
            margin_q    <= '0;
            lowc_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            class_q     <= class_d;
            omax_q      <= omax_d;
`ifdef ARGMAX_MARGIN_EN
            sec_q       <= sec_d;
            margin_q    <= margin_d;
            lowc_q      <= lowc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        max_d       = max_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        class_d     = class_q;
        omax_d      = omax_q;
        lane_k      = '0;
        cand        = '0;
`ifdef ARGMAX_MARGIN_EN
        sec_d       = sec_q;
        margin_d    = margin_q;
        lowc_d      = lowc_q;
        diff        = (DW+1)'(max_q) - (DW+1)'(sec_q);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_scores;
                    max_d   = $signed(in_scores[0]);
                    idx_d   = '0;
                    ptr_d   = '0;
`ifdef ARGMAX_MARGIN_EN
                    sec_d   = MOST_NEG;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Index 0 is the seed, so it is skipped to avoid counting it twice as second max.
                // Lanes are folded in ascending index order with strict >, so ties keep the lowest index.
                for (int l = 0; l < LANES; l++) begin
                    lane_k = ptr_q + PTR_W'(l);
                    if ((lane_k != '0) && (int'(lane_k) < IC)) begin
                        cand = $signed(buf_q[lane_k[IDX_W-1:0]]);
                        if (cand > max_d) begin
`ifdef ARGMAX_MARGIN_EN
                            sec_d = max_d;
`endif
                            max_d = cand;
                            idx_d = lane_k[IDX_W-1:0];
                        end
`ifdef ARGMAX_MARGIN_EN
                        else if (cand > sec_d) begin
                            sec_d = cand;
                        end
`endif
                    end
                end
                ptr_d = ptr_q + PTR_W'(LANES);
                if (int'(ptr_q) + LANES >= IC) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    class_d     = idx_q;
                    omax_d      = max_q;
`ifdef ARGMAX_MARGIN_EN
                    margin_d    = diff;
                    lowc_d      = diff < (DW+1)'(MARGIN_T);
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_class = class_q;
    assign out_max   = omax_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_margin = margin_q;
    assign out_lowc   = lowc_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - randomized self-checking bench for argmax_classifier
// Drives LANES=2/1/3 instances in lockstep; margin checks enabled with ARGMAX_MARGIN_EN.
module tb_argmax_classifier;
    localparam int IC = 10;
    localparam int DW = 16;

    typedef logic [DW-1:0] vec_t [IC];

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  out_ready;
    logic [IC-1:0][DW-1:0] in_scores;
    logic                  ir [3];
    logic                  ov [3];
    logic [3:0]            oc [3];
    logic [DW-1:0]         om [3];
`ifdef ARGMAX_MARGIN_EN
    logic [DW:0]           omg [3];
    logic                  olc [3];
`endif

    int n_vec;
    int n_err;

    argmax_classifier #(.IC(IC), .DW(DW), .LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_scores(in_scores), .out_valid(ov[0]), .out_ready(out_ready),
        .out_class(oc[0]), .out_max(om[0])
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(omg[0]), .out_lowc(olc[0])
`endif
    );
    argmax_classifier #(.IC(IC), .DW(DW), .LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_scores(in_scores), .out_valid(ov[1]), .out_ready(out_ready),
        .out_class(oc[1]), .out_max(om[1])
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(omg[1]), .out_lowc(olc[1])
`endif
    );
    argmax_classifier #(.IC(IC), .DW(DW), .LANES(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_scores(in_scores), .out_valid(ov[2]), .out_ready(out_ready),
        .out_class(oc[2]), .out_max(om[2])
`ifdef ARGMAX_MARGIN_EN
        , .out_margin(omg[2]), .out_lowc(olc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lanes_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    // Reference: first index holding the largest value; second max over all other entries.
    function automatic void model(input vec_t v, output int idx, output int mx, output int mg);
        int sec;
        idx = 0;
        for (int i = 1; i < IC; i++)
            if ($signed(v[i]) > $signed(v[idx])) idx = i;
        mx  = int'($signed(v[idx]));
        sec = -(1 << (DW - 1));
        for (int j = 0; j < IC; j++)
            if (j != idx && int'($signed(v[j])) > sec) sec = int'($signed(v[j]));
        mg = mx - sec;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < IC; i++) in_scores[i] = v[i];
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ir[0] === 1'b1 && ir[1] === 1'b1 && ir[2] === 1'b1) && n < 60) begin
            step();
            n++;
        end
        n_vec++;
        if (!(ir[0] === 1'b1 && ir[1] === 1'b1 && ir[2] === 1'b1)) begin
            n_err++;
            $display("FAIL idle_timeout: in_ready=%b%b%b want 111", ir[0], ir[1], ir[2]);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int exp_idx, exp_max, exp_mg;
        bit seen [3];
        int lat [3];
        logic [3:0] c_cls [3];
        logic [DW-1:0] c_max [3];
`ifdef ARGMAX_MARGIN_EN
        logic [DW:0] c_mg;
        logic c_lc;
        c_mg = '0;
        c_lc = 1'b0;
`endif
        model(v, exp_idx, exp_max, exp_mg);
        wait_idle();
        drive(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < IC; i++) in_scores[i] = DW'($urandom);
        n_vec++;
        if (ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL in_ready_drop: got %b want 0", ir[0]);
        end
        for (int d = 0; d < 3; d++) begin
            seen[d] = 1'b0; lat[d] = 0; c_cls[d] = '0; c_max[d] = '0;
        end
        for (int c = 1; c <= 40; c++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d] === 1'b1) begin
                    seen[d]  = 1'b1;
                    lat[d]   = c;
                    c_cls[d] = oc[d];
                    c_max[d] = om[d];
`ifdef ARGMAX_MARGIN_EN
                    if (d == 0) begin
                        c_mg = omg[0];
                        c_lc = olc[0];
                    end
`endif
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (!seen[d]) begin
                n_err++;
                $display("FAIL result_timeout lanes=%0d: out_valid never high", lanes_of(d));
            end else begin
                if (lat[d] != (IC + lanes_of(d) - 1) / lanes_of(d) + 1) begin
                    n_err++;
                    $display("FAIL latency lanes=%0d: got %0d want %0d", lanes_of(d), lat[d],
                             (IC + lanes_of(d) - 1) / lanes_of(d) + 1);
                end
                n_vec++;
                if (c_cls[d] !== 4'(exp_idx)) begin
                    n_err++;
                    $display("FAIL out_class lanes=%0d: got %0d want %0d", lanes_of(d), c_cls[d], exp_idx);
                end
                n_vec++;
                if (c_max[d] !== DW'(exp_max)) begin
                    n_err++;
                    $display("FAIL out_max lanes=%0d: got %h want %h", lanes_of(d), c_max[d], DW'(exp_max));
                end
            end
        end
`ifdef ARGMAX_MARGIN_EN
        n_vec++;
        if (c_mg !== (DW+1)'(exp_mg) || c_lc !== (exp_mg < 256)) begin
            n_err++;
            $display("FAIL margin: got %h/%b want %h/%b", c_mg, c_lc, (DW+1)'(exp_mg), exp_mg < 256);
        end
`endif
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || oc[d] !== '0 || om[d] !== '0) begin
                n_err++;
                $display("FAIL %s lanes=%0d: ready=%b valid=%b class=%0d max=%h want 1 0 0 0000",
                         tag, lanes_of(d), ir[d], ov[d], oc[d], om[d]);
            end
`ifdef ARGMAX_MARGIN_EN
            n_vec++;
            if (omg[d] !== '0 || olc[d] !== 1'b0) begin
                n_err++;
                $display("FAIL %s_margin lanes=%0d: got %h/%b want 0/0", tag, lanes_of(d), omg[d], olc[d]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_state("reset_state");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_spec_vectors();
        vec_t v;
        v = '{16'hFD00, 16'h0500, 16'h0200, 16'h0900, 16'h0900,
              16'h0000, 16'hFF00, 16'h0400, 16'h0800, 16'h0700};
        run_vector(v);
        for (int i = 0; i < IC; i++) v[i] = 16'hFFFF;
        run_vector(v);
        for (int i = 0; i < IC; i++) v[i] = 16'h8000;
        run_vector(v);
        for (int i = 0; i < IC; i++) begin
            v[i] = DW'($urandom);
            if (v[i] == 16'h7FFF) v[i] = 16'h0000;
        end
        v[9] = 16'h7FFF;
        run_vector(v);
        for (int i = 0; i < IC; i++) v[i] = 16'hFF00;
        v[0] = 16'h0300;
        v[1] = 16'h0280;
        run_vector(v);
        v[4] = 16'h0500;
        v[7] = 16'h0300;
        v[0] = 16'h0100;
        v[1] = 16'h0000;
        run_vector(v);
    endtask

    task automatic test_random();
        vec_t v;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < IC; i++)
                v[i] = (n % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 3)) - 16'd1;
            run_vector(v);
        end
    endtask

    task automatic test_stall();
        vec_t a, b, c;
        int exp_idx, exp_max, exp_mg;
        for (int i = 0; i < IC; i++) begin
            a[i] = DW'($urandom);
            b[i] = DW'($urandom);
            c[i] = DW'($urandom);
        end
        b[5] = 16'h7FFF;
        model(a, exp_idx, exp_max, exp_mg);
        wait_idle();
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        for (int k = 0; k < 20; k++) begin
            if (k < 4) begin
                drive(b);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            n_vec++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || oc[0] !== 4'(exp_idx) || om[0] !== DW'(exp_max)) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d: valid=%b ready=%b class=%0d max=%h want 1 0 %0d %h",
                         k, ov[0], ir[0], oc[0], om[0], exp_idx, DW'(exp_max));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: valid=%b ready=%b want 0 1", ov[0], ir[0]);
        end
        run_vector(c);
    endtask

    task automatic test_reset_mid_scan();
        vec_t a, c;
        for (int i = 0; i < IC; i++) begin
            a[i] = DW'($urandom);
            c[i] = DW'($urandom);
        end
        wait_idle();
        drive(a);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_mid_scan");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_vec++;
            if (ov[0] !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_valid cyc=%0d: got %b want 0", k, ov[0]);
            end
        end
        run_vector(c);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_scores = '0;
        n_vec     = 0;
        n_err     = 0;
        test_reset();
        test_spec_vectors();
        test_random();
        test_stall();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
